// File: rtl/jtcop_pkg.sv
// jtcop_pkg: constants and types shared by the object DMA, address decoder and object renderer.
// JTCOP_OBJDMA_DBLBUF_EN widens the shadow-buffer address by one bank bit.
package jtcop_pkg;

    localparam int OBJ_AW  = 10;    // object RAM word address width (1024 x 16)
    localparam int OBJ_LEN = 1024;  // words copied per obj_copy strobe
    localparam int OBJ_DW  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COPY  = 2'd1,
        DRAIN = 2'd2
    } dma_st_e;

    // Shadow-buffer address width: one extra bank bit when double buffered.
    function automatic int dst_aw(input int aw);
`ifdef JTCOP_OBJDMA_DBLBUF_EN
        return aw + 1;
`else
        return aw;
`endif
    endfunction

endpackage

// File: rtl/jtcop_obj_dma_if.sv
// jtcop_obj_dma_if: trigger, object RAM read port and shadow-buffer write port of the object DMA.
// JTCOP_OBJDMA_DBLBUF_EN adds the bank bit to dst_addr (through jtcop_pkg::dst_aw).
interface jtcop_obj_dma_if
    import jtcop_pkg::*;
#(
    parameter int AW = OBJ_AW,
    parameter int DW = OBJ_DW
) ();
    localparam int DAW = dst_aw(AW);

    logic           obj_copy;
    logic           obj_cs;
    logic [AW-1:0]  src_addr;
    logic           src_rd;
    logic [DW-1:0]  src_data;
    logic [DAW-1:0] dst_addr;
    logic [DW-1:0]  dst_data;
    logic           dst_we;
    logic           busy;
    logic           done;
    logic           rd_bank;

    // DMA side
    modport master (
        input  obj_copy, obj_cs, src_data,
        output src_addr, src_rd, dst_addr, dst_data, dst_we, busy, done, rd_bank
    );

    // Decoder / RAM / renderer side
    modport slave (
        output obj_copy, obj_cs, src_data,
        input  src_addr, src_rd, dst_addr, dst_data, dst_we, busy, done, rd_bank
    );
endinterface

// File: rtl/jtcop_obj_dma_wr.sv
// jtcop_obj_dma_wr: turns a read issued in cycle n into a shadow-buffer write in cycle n+1.
// The object RAM returns data the cycle after the read, which is the write cycle itself,
// so data is forwarded straight through and forced to zero when no write is pending.
module jtcop_obj_dma_wr #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rd_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o
);
    logic          we_q;
    logic [AW-1:0] addr_q;

    // Delay read strobe and address by one cycle to align with returned data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            we_q   <= rd_i;
            addr_q <= addr_i;
        end
    end

    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = we_q ? data_i : '0;

endmodule

// File: rtl/jtcop_obj_dma.sv
// jtcop_obj_dma: copies LEN words of object RAM into the renderer's shadow buffer on each
// obj_copy strobe. CPU accesses (obj_cs) stall the read side; reads in flight always land.
// Optional: JTCOP_OBJDMA_DBLBUF_EN writes the hidden bank and flips rd_bank at done.
module jtcop_obj_dma
    import jtcop_pkg::*;
#(
    parameter int AW  = OBJ_AW,
    parameter int LEN = OBJ_LEN,
    parameter int DW  = OBJ_DW
) (
    input  logic            clk,
    input  logic            rstn,
    jtcop_obj_dma_if.master bus
);
    localparam int          DAW  = dst_aw(AW);
    // Counter is AW+1 bits so LEN = 2^AW reaches its last index without wrapping
    localparam logic [AW:0] LAST = (AW+1)'(LEN - 1);

    dma_st_e        st_q, st_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           rd;
    logic [DAW-1:0] wr_addr;

    assign rd           = (st_q == COPY) && !bus.obj_cs;
    assign bus.src_rd   = rd;
    assign bus.src_addr = cnt_q[AW-1:0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

`ifdef JTCOP_OBJDMA_DBLBUF_EN
    logic bank_q, bank_d;

    // Always write the bank the renderer is not reading
    assign wr_addr     = {~bank_q, cnt_q[AW-1:0]};
    assign bus.rd_bank = bank_q;

    // Hand the freshly written bank to the renderer on the done edge
    always_comb begin
        bank_d = bank_q;
        if (st_q == DRAIN) bank_d = ~bank_q;
    end

    // Bank register; a reset-aborted copy returns display to bank 0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) bank_q <= 1'b0;
        else       bank_q <= bank_d;
    end
`else
    assign wr_addr     = cnt_q[AW-1:0];
    assign bus.rd_bank = 1'b0;
`endif

    // Next-state: triggers are only accepted in IDLE, so strobes while busy are dropped
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (st_q)
            IDLE: if (bus.obj_copy) begin
                st_d   = COPY;
                cnt_d  = '0;
                busy_d = 1'b1;
            end
            COPY: if (rd) begin
                cnt_d = cnt_q + (AW+1)'(1);
                if (cnt_q == LAST) st_d = DRAIN;
            end
            DRAIN: begin
                st_d   = IDLE;
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: st_d = IDLE;
        endcase
    end

    // FSM, read counter and registered status outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    jtcop_obj_dma_wr #(.AW(DAW), .DW(DW)) u_wr (
        .clk    (clk),
        .rstn   (rstn),
        .rd_i   (rd),
        .addr_i (wr_addr),
        .data_i (bus.src_data),
        .we_o   (bus.dst_we),
        .addr_o (bus.dst_addr),
        .data_o (bus.dst_data)
    );

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// tb_jtcop_obj_dma: LEN=8 instance driven by a scenario table, hand sequences and random
// obj_cs patterns; a default LEN=1024 instance for the full-size copy.
// Build with JTCOP_OBJDMA_DBLBUF_EN to also check bank selection.
module tb_jtcop_obj_dma;
    import jtcop_pkg::*;

    localparam int AW  = OBJ_AW;
    localparam int DW  = OBJ_DW;
    localparam int SL  = 8;
    localparam int DAW = dst_aw(AW);

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    jtcop_obj_dma_if #(.AW(AW), .DW(DW)) sb ();
    jtcop_obj_dma_if #(.AW(AW), .DW(DW)) bb ();

    jtcop_obj_dma #(.AW(AW), .LEN(SL), .DW(DW)) u_small (.clk(clk), .rstn(rstn), .bus(sb.master));
    jtcop_obj_dma #(.AW(AW), .DW(DW))           u_big   (.clk(clk), .rstn(rstn), .bus(bb.master));

    logic [DW-1:0] mem [0:1023];

    // Object RAM: data valid the cycle after a read, garbage otherwise
    always @(posedge clk) begin
        sb.src_data <= sb.src_rd ? mem[sb.src_addr] : DW'($urandom);
        bb.src_data <= bb.src_rd ? mem[bb.src_addr] : DW'($urandom);
    end

    int vec = 0;
    int bad = 0;
    bit exp_bank = 1'b0;
    bit cs_v [0:63];

    typedef struct {
        int cs_lo;
        int cs_hi;
        int retrig;
        int exp_done;
    } scen_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int find(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return i;
        return -1;
    endfunction

    function automatic int count_before(input int q[$], input int v);
        int n = 0;
        foreach (q[i]) if (q[i] < v) n++;
        return n;
    endfunction

    task automatic fill_mem(input bit pattern);
        for (int i = 0; i < 1024; i++)
            mem[i] = pattern ? DW'(16'hA000 + i) : DW'($urandom);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " src_addr"}, 64'(sb.src_addr), 0);
        chk({tag, " src_rd"},   64'(sb.src_rd),   0);
        chk({tag, " dst_addr"}, 64'(sb.dst_addr), 0);
        chk({tag, " dst_data"}, 64'(sb.dst_data), 0);
        chk({tag, " dst_we"},   64'(sb.dst_we),   0);
        chk({tag, " busy"},     64'(sb.busy),     0);
        chk({tag, " done"},     64'(sb.done),     0);
        chk({tag, " rd_bank"},  64'(sb.rd_bank),  0);
    endtask

    // Copy on the LEN=8 instance. Cycle 0 carries the obj_copy strobe; the expected
    // schedule is the first SL cycles >= 1 with obj_cs low, writes one cycle later,
    // busy up to the cycle after the last read, done one cycle after that.
    task automatic run_scen(input string nm, input bit skip0, input bit chain,
                            input int retrig, input int exp_done);
        int rd_cyc[$];
        int last, done_at, ri, wi;
        logic [63:0] ea;
        for (int c = 1; c < 64 && rd_cyc.size() < SL; c++)
            if (!cs_v[c]) rd_cyc.push_back(c);
        if (rd_cyc.size() != SL) begin
            vec++; bad++;
            $display("FAIL %s schedule: got %0d reads want %0d", nm, rd_cyc.size(), SL);
            return;
        end
        last = rd_cyc[SL-1];
        done_at = -1;
        for (int c = skip0 ? 1 : 0; c <= last + 2; c++) begin
            @(posedge clk); #1;
            sb.obj_copy = (c == 0) || (c == retrig) || (chain && c == last + 2);
            sb.obj_cs   = cs_v[c];
            @(negedge clk);
            ri = find(rd_cyc, c);
            wi = find(rd_cyc, c - 1);
            chk($sformatf("%s src_rd c%0d", nm, c), 64'(sb.src_rd), 64'(ri >= 0));
            if (c >= 1 && c <= last)
                chk($sformatf("%s src_addr c%0d", nm, c), 64'(sb.src_addr),
                    64'(count_before(rd_cyc, c)));
            chk($sformatf("%s dst_we c%0d", nm, c), 64'(sb.dst_we), 64'(wi >= 0));
            if (wi >= 0) begin
                ea = 64'(wi);
`ifdef JTCOP_OBJDMA_DBLBUF_EN
                if (!exp_bank) ea = ea + (64'd1 << AW);
`endif
                chk($sformatf("%s dst_addr c%0d", nm, c), 64'(sb.dst_addr), ea);
                chk($sformatf("%s dst_data c%0d", nm, c), 64'(sb.dst_data), 64'(mem[wi]));
            end
            chk($sformatf("%s busy c%0d", nm, c), 64'(sb.busy), 64'(c >= 1 && c <= last + 1));
            chk($sformatf("%s done c%0d", nm, c), 64'(sb.done), 64'(c == last + 2));
`ifdef JTCOP_OBJDMA_DBLBUF_EN
            if (c == last + 2) exp_bank = ~exp_bank;
`endif
            chk($sformatf("%s rd_bank c%0d", nm, c), 64'(sb.rd_bank), 64'(exp_bank));
            if (sb.done === 1'b1 && done_at < 0) done_at = c;
        end
        sb.obj_copy = chain;
        if (exp_done >= 0) chk({nm, " done_cycle"}, 64'(done_at), 64'(exp_done));
    endtask

    initial begin
        scen_t tbl [6];
        int n, last_a, zero_after, derr, done_at, c;

        // {obj_cs low..high cycle, retrigger cycle, expected done cycle}
        tbl[0] = '{0, -1, -1, 10};   // unstalled: done at LEN+2
        tbl[1] = '{3,  5, -1, 13};   // three stall cycles
        tbl[2] = '{0, -1,  4, 10};   // retrigger while busy ignored
        tbl[3] = '{1,  1, -1, 11};   // stall on first read slot
        tbl[4] = '{8,  8, -1, 11};   // stall on last read slot
        tbl[5] = '{9, 12, -1, 10};   // obj_cs in DRAIN/IDLE has no effect

        sb.obj_copy = 1'b0; sb.obj_cs = 1'b0;
        bb.obj_copy = 1'b0; bb.obj_cs = 1'b0;
        fill_mem(1'b1);

        #2 rstn = 1'b0;
        #1 check_zero("reset");
        chk("reset big busy", 64'(bb.busy), 0);
        chk("reset big dst_we", 64'(bb.dst_we), 0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 64; i++) cs_v[i] = (i >= tbl[t].cs_lo && i <= tbl[t].cs_hi);
            fill_mem(t == 0);
            run_scen($sformatf("tbl%0d", t), 1'b0, 1'b0, tbl[t].retrig, tbl[t].exp_done);
        end

        // obj_copy coinciding with done starts the next copy
        for (int i = 0; i < 64; i++) cs_v[i] = 1'b0;
        fill_mem(1'b0);
        run_scen("chainA", 1'b0, 1'b1, -1, 10);
        fill_mem(1'b0);
        run_scen("chainB", 1'b1, 1'b0, -1, 10);

        // Random CPU contention and random retriggers
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 64; i++)
                cs_v[i] = (i >= 1 && i < 40) ? ($urandom_range(0, 2) == 0) : 1'b0;
            fill_mem(1'b0);
            run_scen($sformatf("rnd%0d", r), 1'b0, 1'b0,
                     (r % 2 == 1) ? int'($urandom_range(1, SL)) : -1, -1);
        end

        // Reset mid-copy clears everything before the next edge
        @(posedge clk); #1 sb.obj_copy = 1'b1; sb.obj_cs = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 sb.obj_copy = 1'b0;
        end
        @(negedge clk);
        chk("midcopy busy", 64'(sb.busy), 1);
        chk("midcopy src_addr", 64'(sb.src_addr), 4);
        #2 rstn = 1'b0;
        #1 check_zero("abort");
        exp_bank = 1'b0;
        @(negedge clk) rstn = 1'b1;
        for (int i = 0; i < 64; i++) cs_v[i] = 1'b0;
        fill_mem(1'b1);
        run_scen("after_rst", 1'b0, 1'b0, -1, 10);

        // Full-size copy on the default instance
        fill_mem(1'b0);
        @(posedge clk); #1 bb.obj_copy = 1'b1;
        @(posedge clk); #1 bb.obj_copy = 1'b0;
        n = 0; last_a = -1; zero_after = 0; derr = 0; done_at = -1; c = 1;
        while (c < 1100 && done_at < 0) begin
            @(negedge clk);
            if (bb.dst_we === 1'b1) begin
                if (int'(bb.dst_addr[AW-1:0]) != n) derr++;
                if (n < 1024 && bb.dst_data !== mem[n]) derr++;
                if (bb.dst_addr[AW-1:0] == '0 && n > 0) zero_after++;
                last_a = int'(bb.dst_addr[AW-1:0]);
                n++;
            end
            if (bb.done === 1'b1) done_at = c;
            @(posedge clk); #1;
            c++;
        end
        if (done_at < 0) begin
            vec++; bad++;
            $display("FAIL big done_timeout: got none want cycle %0d", 1026);
        end
        chk("big write_count", 64'(n), 1024);
        chk("big last_addr", 64'(last_a), 64'h3FF);
        chk("big zero_rewrite", 64'(zero_after), 0);
        chk("big data_errors", 64'(derr), 0);
        chk("big done_cycle", 64'(done_at), 1026);
        chk("big busy_after", 64'(bb.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/jtcop_obj_dma.md
Name: jtcop_obj_dma

Overview:
- Object-RAM-to-line-buffer copy engine, directly downstream of the address decoder's obj_copy strobe (*DM in schematics).
- On each obj_copy pulse it copies the CPU-visible object RAM (30'8000 window) into the shadow buffer that the object renderer scans.
- The CPU can then rewrite object RAM during the active frame without tearing.
- CPU accesses to object RAM take priority; DMA reads stall while obj_cs is active.

Parameters:
- AW, 10, word address width of object RAM (1024 x 16-bit words = 0x800 bytes).
- LEN, 1024, number of words copied per trigger; 1 ≤ LEN ≤ 2^AW.
- DW, 16, data width.

Ports:
- clk, input, 1, system clock.
- rstn, input, 1, asynchronous active-low reset.
- obj_copy, input, 1, start strobe from decoder; sampled high on a clk edge.
- obj_cs, input, 1, CPU owns the object RAM port this cycle; DMA must not issue a read.
- src_addr, output, AW, object RAM read address.
- src_rd, output, 1, read issued this cycle.
- src_data, input, DW, object RAM data, valid exactly 1 cycle after src_rd.
- dst_addr, output, AW (AW+1 with JTCOP_OBJDMA_DBLBUF_EN), shadow buffer write address.
- dst_data, output, DW, shadow buffer write data.
- dst_we, output, 1, shadow buffer write enable.
- busy, output, 1, copy in progress.
- done, output, 1, one-cycle pulse at completion.
- rd_bank, output, 1, bank the renderer must read; constant 0 without the optional feature.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; src_addr=0, src_rd=0, dst_addr=0, dst_data=0, dst_we=0, busy=0, done=0, rd_bank=0, read counter=0.
- Reset mid-copy aborts immediately. Shadow contents are left partially updated and this is accepted.
- States: IDLE → COPY → DRAIN → IDLE.
- IDLE:
  - obj_copy high at edge k → COPY; busy=1 from k+1; read counter cleared.
- COPY, each cycle:
  - If obj_cs=0: src_rd=1, src_addr=counter; counter increments by 1.
  - If obj_cs=1: src_rd=0; src_addr holds; counter holds.
  - After the read with counter = LEN-1 is issued → DRAIN.
- Write pipeline (all states):
  - dst_we = src_rd registered by 1 cycle.
  - dst_addr = src_addr registered by 1 cycle.
  - dst_data = src_data sampled on that same cycle.
  - An in-flight read always completes even if obj_cs rises the cycle after issue.
- DRAIN: lasts one cycle and performs the final write. Next edge → IDLE with done=1 for exactly one cycle and busy=0.
- Unstalled timing, trigger at edge k:
  - Reads in cycles k+1 … k+LEN.
  - Writes in cycles k+2 … k+LEN+1.
  - done in cycle k+LEN+2.
  - Each cycle of obj_cs=1 while in COPY adds one cycle.
- Retrigger: obj_copy while busy=1 is ignored (no restart, no queueing). obj_copy in the same cycle as done starts a new copy.
- Counter is AW+1 bits wide; LEN = 2^AW terminates correctly with no wrap to 0 mid-copy.

Optional Feature:
- Macro: JTCOP_OBJDMA_DBLBUF_EN.
- Defined:
  - Shadow buffer is two banks; dst_addr MSB = ~rd_bank, so the DMA always writes the bank not being displayed.
  - rd_bank toggles on the same edge that raises done.
  - A reset-aborted copy leaves rd_bank=0.
- Undefined:
  - Single bank; dst_addr is AW bits and rd_bank is tied 0.
  - The renderer may see a mixed frame if the copy overlaps its scan.

Decomposition:
- Shared package jtcop_pkg holds:
  - object RAM size constants (OBJ_AW=10, OBJ_LEN=1024);
  - state encoding typedef (IDLE, COPY, DRAIN).
- The decoder and renderer use the same OBJ_AW constant.
- One natural sub-module, jtcop_obj_dma_wr: the 1-cycle read-to-write pipeline register stage (src_rd/src_addr/src_data → dst_we/dst_addr/dst_data).
- FSM and counter stay in the top module.

Test Plan:
- LEN=8, obj_cs=0, src RAM word n = 16'hA000+n, obj_copy at edge 10 → dst_we in cycles 12–19, dst_addr 0–7 with data A000–A007; done only in cycle 20; busy high in cycles 11–19.
- LEN=8, obj_cs high in cycles 13–15 → no src_rd in 13–15; src_rd in 11,12,16–21; writes continue for the read issued in 12; done 3 cycles later than the unstalled case; all 8 words are correct.
- obj_copy pulsed again at edge 14 during a copy → ignored: counter not reset, single done, no extra writes.
- rstn low at cycle 15 mid-copy → all outputs 0 asynchronously (before the next edge). After release, obj_copy runs a full copy from address 0.
- LEN=1024 (default), obj_cs=0 → exactly 1024 dst_we pulses, last dst_addr=10'h3FF, no write to address 0 after the start.
- With JTCOP_OBJDMA_DBLBUF_EN, two back-to-back copies → first writes dst_addr[10]=1 and rd_bank becomes 1 at done; second writes dst_addr[10]=0 and rd_bank returns to 0.
